// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encodings and status-flag struct for the ALU pipeline
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_LTU = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic ovf;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_mon_if.sv
// rtl/alu_pipe_mon_if.sv - operand/result handshake and rare-counter bundle
// slave  : the pipeline side (alu_pipe_mon)
// master : the side that offers operands and consumes results
interface alu_pipe_mon_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             ovf;
    logic             out_rare;
    logic             cnt_clr;
    logic [CNTW-1:0]  rare_cnt;

    modport slave (
        input  in_valid, a, b, op, out_ready, cnt_clr,
        output in_ready, out_valid, result, carry, zero, ovf, out_rare, rare_cnt
    );

    modport master (
        output in_valid, a, b, op, out_ready, cnt_clr,
        input  in_ready, out_valid, result, carry, zero, ovf, out_rare, rare_cnt
    );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: result and carry/zero/ovf flags
// a_i, b_i  : operands
// op_i      : operation select (alu_op_t encoding)
// result_o  : result modulo 2^WIDTH
// flags_o   : carry (add carry-out / sub borrow), zero, ovf (add/sub signed overflow)
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output alu_flags_t       flags_o
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [SHW-1:0]   shamt;

    assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
    // Top bit of the widened difference is the unsigned borrow (a < b).
    assign diff_w = {1'b0, a_i} - {1'b0, b_i};
    assign shamt  = b_i[SHW-1:0];

    always_comb begin
        result_o      = '0;
        flags_o.carry = 1'b0;
        flags_o.ovf   = 1'b0;
        unique case (alu_op_t'(op_i))
            OP_ADD: begin
                result_o      = sum_w[WIDTH-1:0];
                flags_o.carry = sum_w[WIDTH];
                flags_o.ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                                (sum_w[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                result_o      = diff_w[WIDTH-1:0];
                flags_o.carry = diff_w[WIDTH];
                flags_o.ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                                (diff_w[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_SHL: result_o = a_i << shamt;
            OP_SHR: result_o = a_i >> shamt;
            OP_LTU: result_o[0] = (a_i < b_i);
            default: result_o = '0;
        endcase
        flags_o.zero = (result_o == '0);
    end
endmodule

// File: rtl/alu_pipe_mon.sv
// rtl/alu_pipe_mon.sv - two-stage valid/ready ALU pipeline with all-ones operand monitor
// clk    : rising-edge clock
// rst_n  : asynchronous active-low reset
// bus    : slave side of alu_pipe_mon_if (operand beat in, result beat out,
//          out_rare tag, cnt_clr / rare_cnt saturating monitor counter)
module alu_pipe_mon
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_pipe_mon_if.slave bus
);
    localparam logic [WIDTH-1:0] ONES    = '1;
    localparam logic [CNTW-1:0]  CNT_MAX = '1;

    // S1: operand/op register
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             s1_rare_q, s1_rare_d;

    // S2: result/flags register
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    alu_flags_t       s2_flags_q, s2_flags_d;
    logic             s2_rare_q, s2_rare_d;

    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic             s1_adv;
    logic             in_ready;
    logic             accept;
    logic             in_rare;
    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .op_i     (s1_op_q),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    // in_ready depends only on stage state and out_ready, never on in_valid.
    assign s1_adv   = !s2_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = bus.in_valid && in_ready;
    assign in_rare  = (bus.a == ONES) && (bus.b == ONES);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s1_rare_d   = s1_rare_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        s2_rare_d   = s2_rare_q;
        cnt_d       = cnt_q;

        if (in_ready) begin
            s1_valid_d = bus.in_valid;
        end
        if (accept) begin
            s1_a_d    = bus.a;
            s1_b_d    = bus.b;
            s1_op_d   = bus.op;
            s1_rare_d = in_rare;
        end

        // S2 data only changes when a real beat moves in, so a stalled
        // result stays put and an emptied stage keeps its last value.
        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = core_result;
                s2_flags_d  = core_flags;
                s2_rare_d   = s1_rare_q;
            end
        end

        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (accept && in_rare && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s1_rare_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
            s2_rare_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_rare_q   <= s1_rare_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
            s2_rare_q   <= s2_rare_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = s2_result_q;
    assign bus.carry     = s2_flags_q.carry;
    assign bus.zero      = s2_flags_q.zero;
    assign bus.ovf       = s2_flags_q.ovf;
    assign bus.out_rare  = s2_rare_q;
    assign bus.rare_cnt  = cnt_q;
endmodule

// File: tb/tb_alu_pipe_mon.sv
// tb/tb_alu_pipe_mon.sv - directed self-checking bench for alu_pipe_mon
module tb_alu_pipe_mon;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   chk_cnt;
    int   pass_cnt;
    int   exp_cnt;

    alu_pipe_mon_if #(.WIDTH(8), .CNTW(16)) if0 ();
    alu_pipe_mon_if #(.WIDTH(8), .CNTW(2))  if1 ();

    alu_pipe_mon #(.WIDTH(8), .CNTW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    alu_pipe_mon #(.WIDTH(8), .CNTW(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat through an idle pipeline with out_ready high: offered now,
    // taken at the next edge, result visible after the edge after that.
    task automatic beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [7:0] er, input logic ec,
                        input logic ez, input logic eo, input logic erare);
        if0.a        = a;
        if0.b        = b;
        if0.op       = op;
        if0.in_valid = 1'b1;
        check({tag, ".in_ready"}, 32'(if0.in_ready), 32'd1);
        tick();
        if0.in_valid = 1'b0;
        check({tag, ".early"}, 32'(if0.out_valid), 32'd0);
        tick();
        check({tag, ".out_valid"}, 32'(if0.out_valid), 32'd1);
        check({tag, ".result"},    32'(if0.result),    32'(er));
        check({tag, ".carry"},     32'(if0.carry),     32'(ec));
        check({tag, ".zero"},      32'(if0.zero),      32'(ez));
        check({tag, ".ovf"},       32'(if0.ovf),       32'(eo));
        check({tag, ".out_rare"},  32'(if0.out_rare),  32'(erare));
        if (erare) exp_cnt++;
        check({tag, ".rare_cnt"},  32'(if0.rare_cnt),  32'(exp_cnt));
    endtask

    initial begin
        logic [7:0] got_q[$];
        int         acc;
        int         seen;

        chk_cnt      = 0;
        pass_cnt     = 0;
        exp_cnt      = 0;
        rst_n        = 1'b0;
        if0.in_valid = 1'b0;
        if0.a        = '0;
        if0.b        = '0;
        if0.op       = '0;
        if0.out_ready = 1'b1;
        if0.cnt_clr  = 1'b0;
        if1.in_valid = 1'b0;
        if1.a        = '0;
        if1.b        = '0;
        if1.op       = '0;
        if1.out_ready = 1'b1;
        if1.cnt_clr  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst.out_valid", 32'(if0.out_valid), 32'd0);
        check("rst.rare_cnt",  32'(if0.rare_cnt),  32'd0);
        check("rst.result",    32'(if0.result),    32'd0);
        check("rst.out_rare",  32'(if0.out_rare),  32'd0);
        rst_n = 1'b1;
        tick();
        check("rst.in_ready_after", 32'(if0.in_ready), 32'd1);

        // Directed operation vectors
        beat("add_ff_01", 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        beat("sub_80_01", 8'h80, 8'h01, OP_SUB, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
        beat("shl_81_09", 8'h81, 8'h09, OP_SHL, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("and_ff_ff", 8'hFF, 8'hFF, OP_AND, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        beat("add_ff_ff", 8'hFF, 8'hFF, OP_ADD, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
        beat("xor_5a_5a", 8'h5A, 8'h5A, OP_XOR, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        beat("or_0f_f0",  8'h0F, 8'hF0, OP_OR,  8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("shr_80_03", 8'h80, 8'h03, OP_SHR, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("ltu_03_04", 8'h03, 8'h04, OP_LTU, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("ltu_04_03", 8'h04, 8'h03, OP_LTU, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        beat("sub_03_05", 8'h03, 8'h05, OP_SUB, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
        beat("add_7f_01", 8'h7F, 8'h01, OP_ADD, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure: three beats offered with out_ready low
        tick();
        if0.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            if0.a        = 8'(8'h10 + i);
            if0.b        = 8'h01;
            if0.op       = OP_ADD;
            if0.in_valid = 1'b1;
            #1;
            if (if0.in_ready) acc++;
            tick();
        end
        check("bp.accepted",   32'(acc),           32'd2);
        check("bp.in_ready",   32'(if0.in_ready),  32'd0);
        check("bp.hold_valid", 32'(if0.out_valid), 32'd1);
        check("bp.hold_res0",  32'(if0.result),    32'h11);
        tick();
        check("bp.hold_res1",  32'(if0.result),    32'h11);
        check("bp.in_ready2",  32'(if0.in_ready),  32'd0);
        if0.out_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (if0.out_valid) got_q.push_back(if0.result);
            if (if0.in_valid && if0.in_ready) begin
                tick();
                if0.in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        check("bp.count", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size()) check($sformatf("bp.order%0d", i), 32'(got_q[i]), 32'(8'h11 + i));
        end

        // Reset with both stages full
        if0.out_ready = 1'b0;
        if0.a  = 8'hFF;
        if0.b  = 8'hFF;
        if0.op = OP_AND;
        if0.in_valid = 1'b1;
        tick();
        tick();
        if0.in_valid = 1'b0;
        exp_cnt += 2;
        check("rstmid.full",     32'(if0.out_valid), 32'd1);
        check("rstmid.cnt_pre",  32'(if0.rare_cnt),  32'(exp_cnt));
        check("rstmid.in_ready", 32'(if0.in_ready),  32'd0);
        rst_n = 1'b0;
        #1;
        check("rstmid.out_valid", 32'(if0.out_valid), 32'd0);
        check("rstmid.rare_cnt",  32'(if0.rare_cnt),  32'd0);
        check("rstmid.out_rare",  32'(if0.out_rare),  32'd0);
        exp_cnt = 0;
        tick();
        rst_n = 1'b1;
        if0.out_ready = 1'b1;
        tick();
        check("rstmid.in_ready_after", 32'(if0.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (if0.out_valid) seen++;
            tick();
        end
        check("rstmid.no_stale", 32'(seen), 32'd0);

        // Saturation and clear on the CNTW=2 instance
        if1.a  = 8'hFF;
        if1.b  = 8'hFF;
        if1.op = OP_ADD;
        if1.in_valid = 1'b1;
        tick();
        tick();
        tick();
        check("sat.cnt3", 32'(if1.rare_cnt), 32'd3);
        tick();
        check("sat.cnt4", 32'(if1.rare_cnt), 32'd3);
        if1.cnt_clr = 1'b1;
        tick();
        if1.cnt_clr  = 1'b0;
        if1.in_valid = 1'b0;
        check("sat.clr_wins", 32'(if1.rare_cnt), 32'd0);
        check("sat.out_rare", 32'(if1.out_rare), 32'd1);
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
